race_ctl: RTL and testbench

Game-flow controller for the drag race. It sequences start screen → countdown → race → result, using frame ticks derived from the VGA vsync. It drives the screen-select and countdown digit consumed by the scoreboard/caption path, and enables car motion only during the race. It sits between the keyboard decoder and the scoreboard/renderer in the clk65MHz domain.

---
 rtl/race_ctl.sv | 143 ++++++++++++++
 tb/tb_race_ctl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_ctl.sv
// Drag-race game-flow controller: start -> countdown -> race -> result.
// Frame ticks come from vsync rising edges; all outputs are registered.
module race_ctl #(
    parameter int FRAMES_PER_STEP = 60,
    parameter int FINISH_HOLD     = 300,
    parameter int TIME_W          = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync_in,
    input  logic              key_start,
    input  logic              key_p1,
    input  logic              key_p2,
    input  logic              finish_p1,
    input  logic              finish_p2,
    output logic [1:0]        screen_sel,
    output logic [1:0]        countdown,
    output logic [TIME_W-1:0] elapsed,
    output logic [1:0]        winner,
    output logic [1:0]        false_start,
    output logic              game_active
);
    localparam int FW = $clog2(FRAMES_PER_STEP + 1);
    localparam int HW = $clog2(FINISH_HOLD + 1);
    localparam logic [FW-1:0]     F_LAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [HW-1:0]     H_LAST = HW'(FINISH_HOLD - 1);
    localparam logic [TIME_W-1:0] E_MAX  = '1;

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_COUNT  = 2'd1,
        S_RACE   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t             state, state_d;
    logic               vsync_q, key_start_q;
    logic [FW-1:0]      fcnt, fcnt_d;
    logic [HW-1:0]      hcnt, hcnt_d;
    logic [1:0]         countdown_d, winner_d, fs_d;
    logic [TIME_W-1:0]  elapsed_d;
    logic               tick, press, timeout;

    assign tick       = vsync_in & ~vsync_q;
    assign press      = key_start & ~key_start_q;
    assign screen_sel = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_START;
            vsync_q     <= 1'b0;
            key_start_q <= 1'b0;
            fcnt        <= '0;
            hcnt        <= '0;
            countdown   <= 2'd0;
            elapsed     <= '0;
            winner      <= 2'b00;
            false_start <= 2'b00;
            game_active <= 1'b0;
        end else begin
            state       <= state_d;
            vsync_q     <= vsync_in;
            key_start_q <= key_start;
            fcnt        <= fcnt_d;
            hcnt        <= hcnt_d;
            countdown   <= countdown_d;
            elapsed     <= elapsed_d;
            winner      <= winner_d;
            false_start <= fs_d;
            game_active <= (state_d == S_RACE);
        end
    end

    always_comb begin
        state_d     = state;
        fcnt_d      = fcnt;
        hcnt_d      = hcnt;
        countdown_d = countdown;
        elapsed_d   = elapsed;
        winner_d    = winner;
        fs_d        = false_start;
        timeout     = 1'b0;
        case (state)
            S_START: begin
                if (press) begin
                    state_d     = S_COUNT;
                    countdown_d = 2'd3;
                    fcnt_d      = '0;
                    elapsed_d   = '0;
                    winner_d    = 2'b00;
                    fs_d        = 2'b00;
                end
            end
            S_COUNT: begin
                // a key held on the final GO tick still counts as a jump start
                fs_d = false_start | {key_p2, key_p1};
                if (tick) begin
                    if (fcnt == F_LAST) begin
                        fcnt_d = '0;
                        if (countdown == 2'd1) begin
                            countdown_d = 2'd0;
                            hcnt_d      = '0;
                            case (fs_d)
                                2'b00:   state_d = S_RACE;
                                2'b01:   begin state_d = S_RESULT; winner_d = 2'b10; end
                                2'b10:   begin state_d = S_RESULT; winner_d = 2'b01; end
                                default: begin state_d = S_RESULT; winner_d = 2'b00; end
                            endcase
                        end else begin
                            countdown_d = countdown - 2'd1;
                        end
                    end else begin
                        fcnt_d = fcnt + 1'b1;
                    end
                end
            end
            S_RACE: begin
                if (tick) begin
                    if (elapsed == E_MAX) timeout = 1'b1;
                    else                  elapsed_d = elapsed + 1'b1;
                end
                // a real finish outranks a timeout landing in the same cycle
                if (finish_p1 | finish_p2) begin
                    state_d  = S_RESULT;
                    winner_d = {finish_p2, finish_p1};
                    hcnt_d   = '0;
                end else if (timeout) begin
                    state_d  = S_RESULT;
                    winner_d = 2'b00;
                    hcnt_d   = '0;
                end
            end
            default: begin
                if ((tick && hcnt == H_LAST) || press) begin
                    state_d = S_START;
                    hcnt_d  = '0;
                end else if (tick) begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_race_ctl.sv
// Self-checking bench for race_ctl: directed scenarios plus random traffic
// compared every cycle against a tick-counting reference model.
module tb_race_ctl;
    localparam int FPS = 4;
    localparam int FH  = 8;
    localparam int TW  = 6;
    localparam int EMAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst, vsync_in, key_start, key_p1, key_p2, finish_p1, finish_p2;
    logic [1:0]    screen_sel, countdown, winner, false_start;
    logic [TW-1:0] elapsed;
    logic          game_active;

    int errors = 0;
    int checks = 0;

    // reference model: phase plus one tick count per phase
    int m_phase, m_ticks, m_elapsed, m_winner, m_fs;
    bit m_prev_vs, m_prev_ks;

    race_ctl #(.FRAMES_PER_STEP(FPS), .FINISH_HOLD(FH), .TIME_W(TW)) dut (
        .clk(clk), .rst(rst), .vsync_in(vsync_in), .key_start(key_start),
        .key_p1(key_p1), .key_p2(key_p2), .finish_p1(finish_p1), .finish_p2(finish_p2),
        .screen_sel(screen_sel), .countdown(countdown), .elapsed(elapsed),
        .winner(winner), .false_start(false_start), .game_active(game_active)
    );

    always #5 clk = ~clk;

    function automatic int exp_cd();
        return (m_phase == 1) ? 3 - m_ticks / FPS : 0;
    endfunction

    function automatic logic [14:0] exp_vec();
        return {2'(m_phase), 2'(exp_cd()), 6'(m_elapsed), 2'(m_winner), 2'(m_fs), 1'(m_phase == 2)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {screen_sel, countdown, elapsed, winner, false_start, game_active};
    endfunction

    task automatic model_step();
        bit tick, press;
        tick  = vsync_in && !m_prev_vs;
        press = key_start && !m_prev_ks;
        if (rst) begin
            m_phase = 0; m_ticks = 0; m_elapsed = 0; m_winner = 0; m_fs = 0;
            m_prev_vs = 0; m_prev_ks = 0;
            return;
        end
        m_prev_vs = vsync_in;
        m_prev_ks = key_start;
        case (m_phase)
            0: if (press) begin
                m_phase = 1; m_ticks = 0; m_elapsed = 0; m_winner = 0; m_fs = 0;
            end
            1: begin
                m_fs = m_fs | (key_p1 ? 1 : 0) | (key_p2 ? 2 : 0);
                if (tick) m_ticks++;
                if (m_ticks == 3 * FPS) begin
                    m_ticks  = 0;
                    m_phase  = (m_fs == 0) ? 2 : 3;
                    m_winner = (m_fs == 1) ? 2 : (m_fs == 2) ? 1 : 0;
                end
            end
            2: begin
                if (tick) m_ticks++;
                m_elapsed = (m_ticks > EMAX) ? EMAX : m_ticks;
                if (finish_p1 || finish_p2) begin
                    m_phase = 3; m_ticks = 0;
                    m_winner = (finish_p1 ? 1 : 0) + (finish_p2 ? 2 : 0);
                end else if (m_ticks > EMAX) begin
                    m_phase = 3; m_ticks = 0; m_winner = 0;
                end
            end
            default: begin
                if (tick) m_ticks++;
                if (m_ticks == FH || press) begin m_phase = 0; m_ticks = 0; end
            end
        endcase
    endtask

    // one clock: model consumes the inputs the DUT is about to sample
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            vsync_in = 1'b1; step();
            vsync_in = 1'b0; step();
        end
    endtask

    task automatic pulse_start();
        key_start = 1'b1; step();
        key_start = 1'b0; step();
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        vsync_in = 0; key_start = 0; key_p1 = 0; key_p2 = 0; finish_p1 = 0; finish_p2 = 0;
        do_reset();
        checks++;
        if (dut_vec() !== 15'd0) begin
            errors++; $display("FAIL reset_state: got %h want 0", dut_vec());
        end
    endtask

    task automatic test_countdown();
        key_start = 1'b1; step(); key_start = 1'b0;
        checks++;
        if (screen_sel !== 2'd1 || countdown !== 2'd3) begin
            errors++; $display("FAIL cd_entry: got scr=%0d cd=%0d want 1/3", screen_sel, countdown);
        end
        step();
        ticks(3);
        checks++;
        if (countdown !== 2'd3) begin
            errors++; $display("FAIL cd_3_hold: got %0d want 3", countdown);
        end
        ticks(1);
        checks++;
        if (countdown !== 2'd2) begin
            errors++; $display("FAIL cd_2: got %0d want 2", countdown);
        end
        ticks(4);
        checks++;
        if (countdown !== 2'd1) begin
            errors++; $display("FAIL cd_1: got %0d want 1", countdown);
        end
        ticks(4);
        checks++;
        if (screen_sel !== 2'd2 || countdown !== 2'd0 || game_active !== 1'b1) begin
            errors++; $display("FAIL go: got scr=%0d cd=%0d ga=%0b want 2/0/1",
                               screen_sel, countdown, game_active);
        end
    endtask

    task automatic test_finish();
        ticks(5);
        finish_p2 = 1'b1; step(); finish_p2 = 1'b0;
        checks++;
        if (elapsed !== 6'd5 || winner !== 2'b10 || screen_sel !== 2'd3 || game_active !== 1'b0) begin
            errors++; $display("FAIL finish_p2: got el=%0d win=%b scr=%0d ga=%0b want 5/10/3/0",
                               elapsed, winner, screen_sel, game_active);
        end
        ticks(7);
        checks++;
        if (screen_sel !== 2'd3) begin
            errors++; $display("FAIL hold_7: got scr=%0d want 3", screen_sel);
        end
        ticks(1);
        checks++;
        if (screen_sel !== 2'd0 || winner !== 2'b10 || elapsed !== 6'd5) begin
            errors++; $display("FAIL hold_done: got scr=%0d win=%b el=%0d want 0/10/5",
                               screen_sel, winner, elapsed);
        end
    endtask

    task automatic test_tie();
        pulse_start();
        ticks(12);
        ticks(2);
        finish_p1 = 1'b1; finish_p2 = 1'b1; step();
        finish_p1 = 1'b0; finish_p2 = 1'b0;
        checks++;
        if (winner !== 2'b11 || screen_sel !== 2'd3 || elapsed !== 6'd2) begin
            errors++; $display("FAIL tie: got win=%b scr=%0d el=%0d want 11/3/2", winner, screen_sel, elapsed);
        end
        pulse_start();
        checks++;
        if (screen_sel !== 2'd0 || winner !== 2'b11) begin
            errors++; $display("FAIL result_press: got scr=%0d win=%b want 0/11", screen_sel, winner);
        end
    endtask

    task automatic test_false_start();
        bit ga_seen;
        pulse_start();
        ticks(4);
        key_p1 = 1'b1; step(); key_p1 = 1'b0;
        checks++;
        if (false_start !== 2'b01) begin
            errors++; $display("FAIL fs_p1: got %b want 01", false_start);
        end
        ga_seen = 0;
        repeat (16) begin
            vsync_in = ~vsync_in; step();
            if (game_active) ga_seen = 1;
        end
        checks++;
        if (screen_sel !== 2'd3 || winner !== 2'b10 || ga_seen) begin
            errors++; $display("FAIL fs_result: got scr=%0d win=%b ga_seen=%0b want 3/10/0",
                               screen_sel, winner, ga_seen);
        end
        pulse_start();
        pulse_start();
        key_p1 = 1'b1; key_p2 = 1'b1; step(); key_p1 = 1'b0; key_p2 = 1'b0;
        ticks(12);
        checks++;
        if (screen_sel !== 2'd3 || winner !== 2'b00 || false_start !== 2'b11) begin
            errors++; $display("FAIL fs_both: got scr=%0d win=%b fs=%b want 3/00/11",
                               screen_sel, winner, false_start);
        end
        pulse_start();
    endtask

    task automatic test_timeout();
        int entries;
        bit prev_cd;
        key_start = 1'b1;
        step();
        ticks(12);
        ticks(63);
        checks++;
        if (elapsed !== 6'd63 || screen_sel !== 2'd2) begin
            errors++; $display("FAIL sat: got el=%0d scr=%0d want 63/2", elapsed, screen_sel);
        end
        ticks(1);
        checks++;
        if (elapsed !== 6'd63 || winner !== 2'b00 || screen_sel !== 2'd3) begin
            errors++; $display("FAIL timeout: got el=%0d win=%b scr=%0d want 63/00/3",
                               elapsed, winner, screen_sel);
        end
        entries = 0; prev_cd = 0;
        repeat (20) begin
            vsync_in = ~vsync_in; step();
            if (screen_sel == 2'd1 && !prev_cd) entries++;
            prev_cd = (screen_sel == 2'd1);
        end
        checks++;
        if (entries != 0 || screen_sel !== 2'd0) begin
            errors++; $display("FAIL held_start: got reentries=%0d scr=%0d want 0/0", entries, screen_sel);
        end
        key_start = 1'b0; vsync_in = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        ticks(4);
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if (dut_vec() !== 15'd0) begin
            errors++; $display("FAIL rst_cd: got %h want 0", dut_vec());
        end
        key_start = 1'b1; step(); key_start = 1'b0;
        checks++;
        if (screen_sel !== 2'd1 || countdown !== 2'd3) begin
            errors++; $display("FAIL rst_restart: got scr=%0d cd=%0d want 1/3", screen_sel, countdown);
        end
        ticks(13);
        finish_p1 = 1'b1; step(); finish_p1 = 1'b0;
        ticks(2);
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if (dut_vec() !== 15'd0) begin
            errors++; $display("FAIL rst_result: got %h want 0", dut_vec());
        end
        ticks(FPS - 1);
        pulse_start();
        ticks(5);
        checks++;
        if (countdown !== 2'd2) begin
            errors++; $display("FAIL rst_no_residue: got cd=%0d want 2", countdown);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL model_sync: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int vs_cnt;
        vs_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            if (vs_cnt == 0) begin
                vsync_in = ~vsync_in;
                vs_cnt = $urandom_range(1, 3);
            end else begin
                vs_cnt--;
            end
            if ($urandom_range(0, 19) == 0) key_start = ~key_start;
            key_p1    = ($urandom_range(0, 59) == 0);
            key_p2    = ($urandom_range(0, 59) == 0);
            finish_p1 = ($urandom_range(0, 49) == 0);
            finish_p2 = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 699) == 0);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got scr=%0d cd=%0d el=%0d win=%b fs=%b ga=%0b want %0d/%0d/%0d/%b/%b/%0b",
                         i, screen_sel, countdown, elapsed, winner, false_start, game_active,
                         m_phase, exp_cd(), m_elapsed, 2'(m_winner), 2'(m_fs), m_phase == 2);
            end
        end
        rst = 0; key_p1 = 0; key_p2 = 0; finish_p1 = 0; finish_p2 = 0; key_start = 0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_countdown();
        test_finish();
        test_tie();
        test_false_start();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
